// File: rtl/bvinv_pkg.sv
// rtl/bvinv_pkg.sv - shared op and FSM encodings for the urem inverse solver
package bvinv_pkg;

   // Predicate applied between the remainder and the target t
   typedef enum logic [1:0] {
      OP_SGE = 2'b00,
      OP_SGT = 2'b01,
      OP_UGE = 2'b10,
      OP_UGT = 2'b11
   } op_e;

   // Solver control states
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SEARCH = 2'b01,
      RESP   = 2'b10
   } state_e;

endpackage

// File: rtl/bvurem_pred.sv
// rtl/bvurem_pred.sv - combinational remainder-and-predicate check for one candidate
module bvurem_pred
   import bvinv_pkg::*;
#(
   parameter int W   = 4,
   parameter int POS = 0
) (
   input  logic [W-1:0] s,
   input  logic [W-1:0] t,
   input  op_e          op,
   input  logic [W-1:0] cand,
   output logic         sat
);

   logic [W-1:0] w_dividend;
   logic [W-1:0] w_divisor;
   logic [W-1:0] w_rem;

   // POS selects which side of the urem the candidate occupies
   assign w_dividend = (POS == 0) ? cand : s;
   assign w_divisor  = (POS == 0) ? s : cand;

   // Division by zero leaves the dividend unchanged
   assign w_rem = (w_divisor == '0) ? w_dividend : (w_dividend % w_divisor);

   // Apply the latched predicate to the remainder
   always_comb begin
      sat = 1'b0;
      case (op)
         OP_SGE:  sat = ($signed(w_rem) >= $signed(t));
         OP_SGT:  sat = ($signed(w_rem) >  $signed(t));
         OP_UGE:  sat = (w_rem >= t);
         OP_UGT:  sat = (w_rem >  t);
         default: sat = 1'b0;
      endcase
   end

endmodule

// File: rtl/bvurem_inv_solver.sv
// rtl/bvurem_inv_solver.sv - sequential smallest-witness search for urem predicates (optional BVUREM_INV_SOLVER_CYCLE_COUNT_EN)
module bvurem_inv_solver
   import bvinv_pkg::*;
#(
   parameter int W   = 4,
   parameter int POS = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] s_i,
   input  logic [W-1:0] t_i,
   input  logic [1:0]   op_i,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] x_o,
`ifdef BVUREM_INV_SOLVER_CYCLE_COUNT_EN
   output logic [W:0]   count_o,
`endif
   output logic         found_o
);

   state_e       r_state;
   logic [W-1:0] r_s;
   logic [W-1:0] r_t;
   op_e          r_op;
   logic [W-1:0] r_cand;
   logic [W-1:0] r_x;
   logic         r_found;
   logic         w_sat;

   bvurem_pred #(
      .W   (W),
      .POS (POS)
   ) u_pred (
      .s    (r_s),
      .t    (r_t),
      .op   (r_op),
      .cand (r_cand),
      .sat  (w_sat)
   );

   // Control FSM: accept, scan candidates upward one per cycle, hold result until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_t     <= '0;
         r_op    <= OP_SGE;
         r_cand  <= '0;
         r_x     <= '0;
         r_found <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_s     <= s_i;
                  r_t     <= t_i;
                  r_op    <= op_e'(op_i);
                  r_cand  <= '0;
                  r_state <= SEARCH;
               end
            end
            SEARCH: begin
               if (w_sat) begin
                  r_x     <= r_cand;
                  r_found <= 1'b1;
                  r_state <= RESP;
               end else if (r_cand == {W{1'b1}}) begin
                  r_x     <= '0;
                  r_found <= 1'b0;
                  r_state <= RESP;
               end else begin
                  r_cand  <= r_cand + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_x     <= '0;
                  r_found <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign x_o       = r_x;
   assign found_o   = r_found;

`ifdef BVUREM_INV_SOLVER_CYCLE_COUNT_EN
   logic [W:0] r_count;

   // Count evaluated candidates; cleared while idle, frozen while the response waits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (r_state == IDLE) begin
         r_count <= '0;
      end else if (r_state == SEARCH) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count_o = (r_state == RESP) ? r_count : '0;
`endif

endmodule

// File: tb/tb_bvurem_inv_solver.sv
// tb/tb_bvurem_inv_solver.sv - randomized and directed bench for bvurem_inv_solver
`timescale 1ns/1ps
module tb_bvurem_inv_solver;

   localparam int W = 4;
   localparam int N = 1 << W;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic         a_req_valid = 1'b0, a_req_ready, a_rsp_valid, a_rsp_ready = 1'b0, a_found;
   logic [W-1:0] a_s = '0, a_t = '0, a_x;
   logic [1:0]   a_op = '0;
   logic [W:0]   a_count;

   logic         b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_ready = 1'b0, b_found;
   logic [W-1:0] b_s = '0, b_t = '0, b_x;
   logic [1:0]   b_op = '0;
   logic [W:0]   b_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bvurem_inv_solver #(.W(W), .POS(0)) dut_a (
      .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .s_i(a_s), .t_i(a_t), .op_i(a_op), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .x_o(a_x),
`ifdef BVUREM_INV_SOLVER_CYCLE_COUNT_EN
      .count_o(a_count),
`endif
      .found_o(a_found)
   );

   bvurem_inv_solver #(.W(W), .POS(1)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .s_i(b_s), .t_i(b_t), .op_i(b_op), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .x_o(b_x),
`ifdef BVUREM_INV_SOLVER_CYCLE_COUNT_EN
      .count_o(b_count),
`endif
      .found_o(b_found)
   );

`ifndef BVUREM_INV_SOLVER_CYCLE_COUNT_EN
   assign a_count = '0;
   assign b_count = '0;
`endif

   // Reference: brute-force scan of all x with plain integer arithmetic
   function automatic int to_signed(input int v);
      return (v >= N/2) ? v - N : v;
   endfunction

   function automatic void model(input int pos, input int s, input int t, input int op,
                                 output bit f, output int x);
      int dvd, dvs, r;
      bit ok;
      f = 0;
      x = 0;
      for (int c = 0; c < N; c++) begin
         dvd = (pos == 0) ? c : s;
         dvs = (pos == 0) ? s : c;
         r   = (dvs == 0) ? dvd : dvd % dvs;
         case (op)
            0:       ok = to_signed(r) >= to_signed(t);
            1:       ok = to_signed(r) >  to_signed(t);
            2:       ok = r >= t;
            default: ok = r >  t;
         endcase
         if (ok) begin
            f = 1;
            x = c;
            return;
         end
      end
   endfunction

   // Issue one request, wait (bounded) for the response, capture it, then handshake
   task automatic run_req(input int pos, input int s, input int t, input int op,
                          output bit acc, output bit tmo, output int lat,
                          output bit f, output int x, output int cnt);
      @(negedge clk);
      if (pos == 0) begin
         a_s = W'(s); a_t = W'(t); a_op = 2'(op); a_req_valid = 1'b1;
         acc = a_req_ready;
      end else begin
         b_s = W'(s); b_t = W'(t); b_op = 2'(op); b_req_valid = 1'b1;
         acc = b_req_ready;
      end
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      lat = 0;
      tmo = 1;
      for (int i = 0; i < 2 * N + 4; i++) begin
         @(posedge clk); #1;
         lat++;
         if ((pos == 0) ? a_rsp_valid : b_rsp_valid) begin
            tmo = 0;
            break;
         end
      end
      f   = (pos == 0) ? a_found : b_found;
      x   = (pos == 0) ? int'(a_x) : int'(b_x);
      cnt = (pos == 0) ? int'(a_count) : int'(b_count);
      if (pos == 0) a_rsp_ready = 1'b1; else b_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
      b_rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_tests++;
      if ({a_req_ready, a_rsp_valid, a_x, a_found, a_count} !== {1'b1, 1'b0, 4'd0, 1'b0, 5'd0}) begin
         n_fail++;
         $display("FAIL reset_a: rdy=%b vld=%b x=%0d f=%b cnt=%0d, want 1 0 0 0 0",
                  a_req_ready, a_rsp_valid, a_x, a_found, a_count);
      end
      n_tests++;
      if ({b_req_ready, b_rsp_valid, b_x, b_found, b_count} !== {1'b1, 1'b0, 4'd0, 1'b0, 5'd0}) begin
         n_fail++;
         $display("FAIL reset_b: rdy=%b vld=%b x=%0d f=%b cnt=%0d, want 1 0 0 0 0",
                  b_req_ready, b_rsp_valid, b_x, b_found, b_count);
      end
   endtask

   // One solved request checked against the model (found, x, latency, accept, count)
   task automatic check_case(input string name, input int pos, input int s, input int t, input int op);
      bit acc, tmo, f, ef;
      int lat, x, cnt, ex, elat;
      model(pos, s, t, op, ef, ex);
      elat = ef ? ex + 1 : N;
      run_req(pos, s, t, op, acc, tmo, lat, f, x, cnt);
      n_tests++;
      if (!acc || tmo || f !== ef || x != ex || lat != elat) begin
         n_fail++;
         $display("FAIL %s pos=%0d s=%0d t=%0d op=%0d: acc=%b tmo=%b found=%b x=%0d lat=%0d, want acc=1 tmo=0 found=%b x=%0d lat=%0d",
                  name, pos, s, t, op, acc, tmo, f, x, lat, ef, ex, elat);
      end
`ifdef BVUREM_INV_SOLVER_CYCLE_COUNT_EN
      n_tests++;
      if (cnt != elat) begin
         n_fail++;
         $display("FAIL %s_count: count=%0d want %0d", name, cnt, elat);
      end
`endif
   endtask

   task automatic test_directed();
      check_case("sge_s3_t2",      0, 3, 2, 0);
      check_case("sge_s3_t7_none", 0, 3, 7, 0);
      check_case("sge_s0_t7",      0, 0, 7, 0);
      check_case("sge_s0_tneg8",   0, 0, 8, 0);
      check_case("pos1_uge_none",  1, 13, 14, 2);
      check_case("pos1_ugt_x0",    1, 7, 3, 3);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         check_case("rand", i % 2, int'($urandom_range(N - 1)), int'($urandom_range(N - 1)),
                    int'($urandom_range(3)));
   endtask

   task automatic test_back_to_back();
      int lat;
      bit tmo, stable, rdy_low;
      logic [W-1:0] x0;
      // first request: s=3 t=2 sge -> x=2
      @(negedge clk);
      a_s = 4'd3; a_t = 4'd2; a_op = 2'd0; a_req_valid = 1'b1;
      @(posedge clk); #1;
      // second request offered continuously: s=5 t=4 uge -> x=4
      a_s = 4'd5; a_t = 4'd4; a_op = 2'd2;
      tmo = 1;
      for (int i = 0; i < 2 * N; i++) begin
         @(posedge clk); #1;
         if (a_rsp_valid) begin tmo = 0; break; end
      end
      x0 = a_x;
      stable = 1; rdy_low = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (a_x !== x0 || a_rsp_valid !== 1'b1 || a_found !== 1'b1) stable = 0;
         if (a_req_ready !== 1'b0) rdy_low = 0;
      end
      n_tests++;
      if (tmo || x0 !== 4'd2 || !stable || !rdy_low) begin
         n_fail++;
         $display("FAIL b2b_hold: tmo=%b x=%0d stable=%b rdy_low=%b, want 0 2 1 1", tmo, x0, stable, rdy_low);
      end
      a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
      n_tests++;
      if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_x !== 4'd0) begin
         n_fail++;
         $display("FAIL b2b_idle: rdy=%b vld=%b x=%0d, want 1 0 0", a_req_ready, a_rsp_valid, a_x);
      end
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      lat = 0; tmo = 1;
      for (int i = 0; i < 2 * N; i++) begin
         @(posedge clk); #1;
         lat++;
         if (a_rsp_valid) begin tmo = 0; break; end
      end
      n_tests++;
      if (tmo || a_x !== 4'd4 || a_found !== 1'b1 || lat != 5) begin
         n_fail++;
         $display("FAIL b2b_second: tmo=%b x=%0d found=%b lat=%0d, want 0 4 1 5", tmo, a_x, a_found, lat);
      end
      a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_search();
      bit seen;
      @(negedge clk);
      a_s = 4'd3; a_t = 4'd7; a_op = 2'd0; a_req_valid = 1'b1;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_tests++;
      if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_found !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: rdy=%b vld=%b found=%b, want 1 0 0", a_req_ready, a_rsp_valid, a_found);
      end
      seen = 0;
      for (int i = 0; i < 2 * N; i++) begin
         @(posedge clk); #1;
         if (a_rsp_valid) seen = 1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL rst_no_rsp: rsp_valid seen=%b, want 0", seen);
      end
      check_case("after_rst", 0, 3, 2, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_search();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
